// File: rtl/hysteresis_stream_if.sv
// FIFO-side bundle for hysteresis_stream: input FIFO read port and output FIFO write port.
// master = the hysteresis stage, slave = the FIFO/environment side.
interface hysteresis_stream_if #(
  parameter int PIX_W = 8
) ();
  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;

  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_empty, in_dout, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_empty, in_dout, out_full
  );
endinterface

// File: rtl/hysteresis_stream.sv
// Streaming 3x3 Canny hysteresis stage over a raster-order FIFO stream with self-generated end-of-frame padding.
// Optional macro HYST_BINARY_OUT_EN: kept pixels are emitted as all-ones (edge map) instead of their magnitude.
module hysteresis_stream #(
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 720,
  parameter int PIX_W    = 8,
  parameter int DEF_HIGH = 48,
  parameter int DEF_LOW  = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PIX_W-1:0]    high_thresh,
  input  logic [PIX_W-1:0]    low_thresh,
  hysteresis_stream_if.master fifo,
  output logic                busy,
  output logic                frame_done
);

  localparam int SR_LEN = 2*WIDTH + 3;
  localparam int TOTAL  = WIDTH*HEIGHT + WIDTH + 1;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int COL_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_PRO  = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_RUN  = CNT_W'(WIDTH*HEIGHT);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(TOTAL);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {PROLOGUE, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] advCnt_q, advCnt_d;
  logic [PIX_W-1:0] sr_q [0:SR_LEN-1];
  logic [PIX_W-1:0] sr_d [0:SR_LEN-1];
  logic [PIX_W-1:0] high_q, low_q;
  logic [PIX_W-1:0] outDin_q;
  logic             outValid_q, outLast_q, busy_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic             stall, inRdEn, outWrEn, advance, load, firstRead, frameEnd;
  logic [PIX_W-1:0] sample, centre, result;
  logic             nbrHigh, border, keep, lastPix;

  // A full output register that cannot drain freezes the whole pipeline, input side included.
  assign stall     = outValid_q & fifo.out_full;
  assign outWrEn   = outValid_q & ~fifo.out_full & ~reset;
  assign advCnt_d  = advCnt_q + CNT_W'(advance);
  assign firstRead = (state_q == PROLOGUE) & advance & (advCnt_q == '0);
  assign frameEnd  = (state_q == DRAIN) & advance & (advCnt_d == CNT_END);

  always_ff @(posedge clock) begin
    if (reset) state_q <= PROLOGUE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PROLOGUE: if (advance && advCnt_d == CNT_PRO) state_d = RUN;
      RUN:      if (advance && advCnt_d == CNT_RUN) state_d = DRAIN;
      DRAIN:    if (frameEnd)                       state_d = PROLOGUE;
      default:                                      state_d = PROLOGUE;
    endcase
  end

  always_comb begin
    inRdEn  = 1'b0;
    advance = 1'b0;
    load    = 1'b0;
    sample  = '0;
    case (state_q)
      PROLOGUE: begin
        inRdEn  = ~stall & ~fifo.in_empty & ~reset;
        advance = inRdEn;
        sample  = fifo.in_dout;
      end
      RUN: begin
        inRdEn  = ~stall & ~fifo.in_empty & ~reset;
        advance = inRdEn;
        load    = inRdEn;
        sample  = fifo.in_dout;
      end
      DRAIN: begin
        advance = ~stall;
        load    = ~stall;
      end
      default: ;
    endcase
  end

  // Next window contents; the result is evaluated on the shifted window so it lands in the same edge.
  always_comb begin
    for (int i = 0; i < SR_LEN; i++) sr_d[i] = sr_q[i];
    if (advance) begin
      for (int i = 0; i < SR_LEN - 1; i++) sr_d[i] = sr_q[i + 1];
      sr_d[SR_LEN-1] = sample;
    end
  end

  always_comb begin
    centre  = sr_d[WIDTH+1];
    nbrHigh = (sr_d[0] > high_q) | (sr_d[1] > high_q) | (sr_d[2] > high_q) |
              (sr_d[WIDTH] > high_q) | (sr_d[WIDTH+2] > high_q) |
              (sr_d[2*WIDTH] > high_q) | (sr_d[2*WIDTH+1] > high_q) | (sr_d[2*WIDTH+2] > high_q);
    border  = (row_q == '0) | (row_q == ROW_LAST) | (col_q == '0) | (col_q == COL_LAST);
    keep    = ~border & ((centre > high_q) | ((centre > low_q) & nbrHigh));
    lastPix = (row_q == ROW_LAST) & (col_q == COL_LAST);
`ifdef HYST_BINARY_OUT_EN
    result  = keep ? '1 : '0;
`else
    result  = keep ? centre : '0;
`endif
  end

  // Datapath and status registers; thresholds are frozen at the first read of each frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      advCnt_q   <= '0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
      high_q     <= PIX_W'(DEF_HIGH);
      low_q      <= PIX_W'(DEF_LOW);
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outDin_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      advCnt_q   <= frameEnd ? '0 : advCnt_d;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= sr_d[i];
      if (firstRead) begin
        high_q <= high_thresh;
        low_q  <= low_thresh;
      end
      outValid_q <= load | (outValid_q & ~outWrEn);
      if (load) begin
        outDin_q  <= result;
        outLast_q <= lastPix;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (firstRead)       busy_q <= 1'b1;
      else if (frame_done) busy_q <= 1'b0;
    end
  end

  assign fifo.in_rd_en  = inRdEn;
  assign fifo.out_wr_en = outWrEn;
  assign fifo.out_din   = outDin_q;
  assign frame_done     = outWrEn & outLast_q;
  assign busy           = busy_q;

endmodule
